// File: rtl/systolic_input_feeder.sv
// Upstream feeder for an NxN systolic array: latches one operand-matrix pair,
// streams A rows and B columns with a per-lane diagonal skew, then waits for the array's result.
module systolic_input_feeder #(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N*N*DW-1:0] in_a,
    input  logic [N*N*DW-1:0] in_b,
    output logic [N*DW-1:0]   a_out,
    output logic [N*DW-1:0]   b_out,
    output logic              acc_clr,
    input  logic              array_valid,
    output logic              busy,
    output logic              done
);

    localparam int TW = (2*N-1 > 1) ? $clog2(2*N-1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(2*N-2);

    typedef enum logic [1:0] {
        IDLE,
        PREP,
        STREAM,
        DRAIN
    } state_t;

    state_t            state;
    logic [TW-1:0]     t;
    logic [N*N*DW-1:0] a_mem;
    logic [N*N*DW-1:0] b_mem;
    logic [N*DW-1:0]   a_beat;
    logic [N*DW-1:0]   b_beat;

    // Lane i sees the element whose index along the stream direction is t-i; lanes outside that window stay 0.
    always_comb begin
        a_beat = '0;
        b_beat = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(t) >= i && int'(t) - i < N) begin
                a_beat[i*DW +: DW] = a_mem[(i*N + int'(t) - i)*DW +: DW];
                b_beat[i*DW +: DW] = b_mem[((int'(t) - i)*N + i)*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            t        <= '0;
            a_mem    <= '0;
            b_mem    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc_clr  <= 1'b0;
            a_out    <= '0;
            b_out    <= '0;
        end else begin
            done    <= 1'b0;
            acc_clr <= 1'b0;
            a_out   <= '0;
            b_out   <= '0;
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_mem    <= in_a;
                        b_mem    <= in_b;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= PREP;
                    end
                end
                PREP: begin
                    acc_clr <= 1'b1;
                    t       <= '0;
                    state   <= STREAM;
                end
                STREAM: begin
                    a_out <= a_beat;
                    b_out <= b_beat;
                    // Counter parks at its last value; PREP rewinds it for the next product.
                    if (t == T_LAST) begin
                        state <= DRAIN;
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                DRAIN: begin
                    if (array_valid) begin
                        done     <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Self-checking bench for systolic_input_feeder: a cycle-timeline model of the feeder's
// observable behaviour checked every negedge, plus literal beat tables for known matrices.
module tb_systolic_input_feeder;

    localparam int N  = 3;
    localparam int DW = 8;

    typedef logic [N*DW-1:0] beat_t [2*N-1];

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N*N*DW-1:0] in_a = '0;
    logic [N*N*DW-1:0] in_b = '0;
    logic [N*DW-1:0]   a_out;
    logic [N*DW-1:0]   b_out;
    logic              acc_clr;
    logic              array_valid = 1'b0;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    bit cmpOn  = 1'b0;

    always #5 clk = ~clk;

    systolic_input_feeder #(.N(N), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .a_out      (a_out),
        .b_out      (b_out),
        .acc_clr    (acc_clr),
        .array_valid(array_valid),
        .busy       (busy),
        .done       (done)
    );

    // Model: operands as plain matrices, behaviour as a timeline counted in cycles since acceptance.
    int              mA [N][N];
    int              mB [N][N];
    logic            exp_ready, exp_busy, exp_done, exp_clr;
    logic [N*DW-1:0] exp_a, exp_b;
    bit              m_idle;
    int              phase;
    int              acceptCount = 0;

    function automatic logic [N*DW-1:0] beatA(input int tt);
        logic [N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (tt - i >= 0 && tt - i < N) r[i*DW +: DW] = DW'(mA[i][tt-i]);
        return r;
    endfunction

    function automatic logic [N*DW-1:0] beatB(input int tt);
        logic [N*DW-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++)
            if (tt - j >= 0 && tt - j < N) r[j*DW +: DW] = DW'(mB[tt-j][j]);
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin : model_b
        int ph;
        if (!rst) begin
            exp_ready <= 1'b1;
            exp_busy  <= 1'b0;
            exp_done  <= 1'b0;
            exp_clr   <= 1'b0;
            exp_a     <= '0;
            exp_b     <= '0;
            m_idle    <= 1'b1;
            phase     <= 0;
        end else begin
            exp_done <= 1'b0;
            exp_clr  <= 1'b0;
            exp_a    <= '0;
            exp_b    <= '0;
            if (m_idle) begin
                if (in_valid) begin
                    for (int r = 0; r < N; r++)
                        for (int c = 0; c < N; c++) begin
                            mA[r][c] <= int'(in_a[(r*N+c)*DW +: DW]);
                            mB[r][c] <= int'(in_b[(r*N+c)*DW +: DW]);
                        end
                    m_idle      <= 1'b0;
                    phase       <= 0;
                    exp_ready   <= 1'b0;
                    exp_busy    <= 1'b1;
                    acceptCount <= acceptCount + 1;
                end
            end else begin
                ph = phase + 1;
                phase <= ph;
                if (ph == 1) begin
                    exp_clr <= 1'b1;
                end else if (ph <= 2*N) begin
                    exp_a <= beatA(ph - 2);
                    exp_b <= beatB(ph - 2);
                end else if (array_valid) begin
                    exp_done  <= 1'b1;
                    exp_ready <= 1'b1;
                    exp_busy  <= 1'b0;
                    m_idle    <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmpOn) begin
            checkOutput("cyc_in_ready", 64'(in_ready), 64'(exp_ready));
            checkOutput("cyc_busy",     64'(busy),     64'(exp_busy));
            checkOutput("cyc_done",     64'(done),     64'(exp_done));
            checkOutput("cyc_acc_clr",  64'(acc_clr),  64'(exp_clr));
            checkOutput("cyc_a_out",    64'(a_out),    64'(exp_a));
            checkOutput("cyc_b_out",    64'(b_out),    64'(exp_b));
        end
    end

    task automatic applyStimulus(input logic [N*N*DW-1:0] a, input logic [N*N*DW-1:0] b);
        @(posedge clk); #2;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic checkStream(input beat_t la, input beat_t lb);
        @(posedge clk); #1;
        checkOutput("lit_acc_clr", 64'(acc_clr), 64'd1);
        checkOutput("lit_prep_a",  64'(a_out),   64'd0);
        for (int k = 0; k < 2*N-1; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("lit_a_beat%0d", k), 64'(a_out), 64'(la[k]));
            checkOutput($sformatf("lit_b_beat%0d", k), 64'(b_out), 64'(lb[k]));
            checkOutput($sformatf("model_a_beat%0d", k), 64'(exp_a), 64'(la[k]));
            checkOutput($sformatf("model_b_beat%0d", k), 64'(exp_b), 64'(lb[k]));
        end
    endtask

    task automatic completeOp(input int extra);
        int guard = 0;
        while (!(!m_idle && phase > 2*N) && guard < 50) begin
            @(posedge clk); #2;
            guard++;
        end
        checkOutput("drain_reached", 64'(guard < 50), 64'd1);
        repeat (extra) @(posedge clk);
        #2;
        array_valid = 1'b1;
        @(posedge clk); #2;
        array_valid = 1'b0;
    endtask

    localparam logic [N*N*DW-1:0] MAT_SEQ = 72'h090807060504030201;
    localparam logic [N*N*DW-1:0] MAT_ID  = 72'h010000000100000001;

    initial begin : main
        beat_t litA, litB, litI;
        int base;
        litA = '{24'h000001, 24'h000402, 24'h070503, 24'h080600, 24'h090000};
        litB = '{24'h000001, 24'h000204, 24'h030507, 24'h060800, 24'h090000};
        litI = '{24'h000001, 24'h000000, 24'h000100, 24'h000000, 24'h010000};

        // Asynchronous reset before any clock edge
        #3 rst = 1'b0;
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_busy",     64'(busy),     64'd0);
        checkOutput("rst_done",     64'(done),     64'd0);
        checkOutput("rst_acc_clr",  64'(acc_clr),  64'd0);
        checkOutput("rst_a_out",    64'(a_out),    64'd0);
        checkOutput("rst_b_out",    64'(b_out),    64'd0);
        cmpOn = 1'b1;
        @(negedge clk); #2;
        rst = 1'b1;

        // Skew check, then a held-off completion handshake
        $display("[TB] skew and completion");
        applyStimulus(MAT_SEQ, MAT_SEQ);
        checkStream(litA, litB);
        @(posedge clk); #1;
        checkOutput("drain_a_zero", 64'(a_out), 64'd0);
        checkOutput("drain_busy0",  64'(busy),   64'd1);
        for (int k = 1; k < 10; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("drain_busy%0d", k), 64'(busy), 64'd1);
            checkOutput($sformatf("drain_nodone%0d", k), 64'(done), 64'd0);
        end
        #1 array_valid = 1'b1;
        @(posedge clk); #1;
        checkOutput("done_pulse",    64'(done),     64'd1);
        checkOutput("done_in_ready", 64'(in_ready), 64'd1);
        checkOutput("done_busy",     64'(busy),     64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("idle_valid_nodone%0d", k), 64'(done), 64'd0);
        end
        #1 array_valid = 1'b0;

        // Backpressure: second pair offered during the whole first operation
        $display("[TB] backpressure");
        base = acceptCount;
        @(posedge clk); #2;
        in_a = {$urandom, $urandom, $urandom};
        in_b = {$urandom, $urandom, $urandom};
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_a = MAT_ID;
        in_b = MAT_SEQ;
        completeOp(3);
        for (int g = 0; g < 20 && acceptCount != base + 2; g++) begin
            @(posedge clk); #2;
        end
        in_valid = 1'b0;
        checkOutput("bp_second_accept", 64'(acceptCount - base), 64'd2);
        @(posedge clk); #1;
        checkOutput("bp_acc_clr", 64'(acc_clr), 64'd1);
        completeOp(1);

        // Reset in the middle of a stream, then a clean restart
        $display("[TB] mid-stream reset");
        applyStimulus({9{8'hA5}}, {9{8'h5A}});
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("mid_rst_a_out",    64'(a_out),    64'd0);
        checkOutput("mid_rst_b_out",    64'(b_out),    64'd0);
        checkOutput("mid_rst_busy",     64'(busy),     64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("mid_rst_done",     64'(done),     64'd0);
        @(negedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        applyStimulus(MAT_SEQ, MAT_SEQ);
        checkStream(litA, litB);
        completeOp(0);

        // Identity B operand
        $display("[TB] identity B");
        applyStimulus(MAT_SEQ, MAT_ID);
        checkStream(litA, litI);
        completeOp(2);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/systolic_input_feeder.md
# systolic_input_feeder

- Upstream stage of the 3x3 systolic array.
- Accepts a complete pair of N×N operand matrices in one handshake and stores them.
- Drives the array's A and B edge buses with the diagonal skew the array requires: lane i is delayed by i cycles.
- Pulses an accumulator-clear before each matrix product, then waits for the array's valid to report completion.
- The matrix pair is loaded once, so software or a DMA front-end never hand-skews operands.

## Interface

Parameters:
- N, 3, array dimension (rows = columns).
- DW, 8, operand element width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair available.
- in_ready  out  1  feeder can accept a pair.
- in_a  in  N*N*DW  matrix A; element (r,c) at bits [(r*N+c)*DW +: DW].
- in_b  in  N*N*DW  matrix B; same packing.
- a_out  out  N*DW  to array A bus; lane i (row i) at [i*DW +: DW].
- b_out  out  N*DW  to array B bus; lane j (column j) at [j*DW +: DW].
- acc_clr  out  1  one-cycle clear pulse to array accumulators.
- array_valid  in  1  array's result-valid flag.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse when the array reports valid.

## Operation

- All outputs are registered.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready at a rising edge, latch in_a/in_b into internal storage and go to PREP.
  - PREP: one cycle. acc_clr=1; a_out/b_out=0. Go to STREAM with t=0.
  - STREAM: t counts 0..2N-2. At each t:
    - a_out lane i = A[i][t-i] if 0 ≤ t-i < N, else 0.
    - b_out lane j = B[t-j][j] if 0 ≤ t-j < N, else 0.
    - After t=2N-2, go to DRAIN.
  - DRAIN: a_out/b_out=0. Stay until array_valid is sampled 1. Then go to IDLE and pulse done.
- busy=1 in PREP, STREAM and DRAIN.
- in_ready=0 outside IDLE. in_valid there is ignored, and latched operands are never overwritten mid-operation.
- array_valid sampled outside DRAIN is ignored and produces no done.
- t counter width is clog2(2N-1). It stops at 2N-2 and never wraps.
- Operands pass through unmodified: no arithmetic, no sign handling. Lanes that are outside their window are forced to exactly 0.

## Timing

- Reset (rst=0, asynchronous), values hold while rst=0:
  - State IDLE, t=0, operand storage=0.
  - in_ready=1, busy=0, done=0, acc_clr=0, a_out=0, b_out=0.
- Accept at edge k: PREP outputs (acc_clr=1) are visible after edge k+1, i.e. one cycle after acceptance.
- First stream beat t=0 follows one cycle after that. STREAM lasts exactly 2N-1 cycles (5 for N=3).
- in_ready deasserts in the cycle after acceptance.
- in_ready reasserts in the cycle after array_valid is sampled in DRAIN; done=1 in that same cycle.
- A back-to-back accept is allowed on the first IDLE cycle.
- Minimum accept-to-accept spacing: 2N+2 cycles, plus the DRAIN wait.
- Reset asserted mid-STREAM or mid-DRAIN: all outputs go to their reset values immediately, with no done pulse. Latched operands are discarded.

## Test plan

1. Reset:
   - Stimulus: assert rst=0 mid-cycle.
   - Response: all outputs at reset values without a clock edge; in_ready=1.
2. Skew check (N=3):
   - Stimulus: A = B = [[1,2,3],[4,5,6],[7,8,9]].
   - Response: acc_clr one cycle, then the beats below (lanes listed 0,1,2), then zeros.
     - a_out: (1,0,0), (2,4,0), (3,5,7), (0,6,8), (0,0,9).
     - b_out: (1,0,0), (4,2,0), (7,5,3), (0,8,6), (0,0,9).
3. Completion handshake:
   - Stimulus: hold array_valid=0 for 10 DRAIN cycles, then raise it.
   - Response: busy held for all 10 cycles; done is a single pulse; in_ready=1 in the same cycle; no done while array_valid is high in IDLE.
4. Backpressure:
   - Stimulus: hold in_valid=1 with different operands during STREAM.
   - Response: output beats remain those of the first pair; the second pair is accepted only in IDLE and streams next, with its own acc_clr.
5. Mid-operation reset:
   - Stimulus: rst=0 at t=2.
   - Response: outputs are 0 at once; after release, a new pair streams correctly from t=0.
6. Against the array:
   - Stimulus: connect the systolic array and feed test 2's matrices.
   - Response: C = [30,36,42,66,81,96,102,126,150]. A second run with identity B returns A exactly, proving acc_clr works.
